sc_lane_shift_bank: RTL and testbench
=====================================

// Module: sc_lane_shift_bank
// PURPOSE
//  Bank of NUM_LANES independent background-lane rotators for the playfield (road/river rows).
//  Each lane holds a LANE_WIDTH-bit pattern and rotates one bit left or right every PERIOD cycles.
//  Per-lane direction and period are runtime-configurable; lanes are loadable individually.
//  Sits between the level-setup FSM (writes patterns/config) and collision/video logic (reads bus).
// PARAMETERS
//  NUM_LANES        8        number of lanes
//  LANE_WIDTH       16       bits per lane pattern (>=2)
//  PERIOD_WIDTH     8        width of per-lane step period
//  LANESEL_WIDTH    3        lane index width; must satisfy 2**LANESEL_WIDTH >= NUM_LANES
//  DATA_FIXED_INIT  16'h0000 pattern applied to every lane by clear
// PORTS
//  SC_LaneShiftBank_CLOCK_50       in   1                     system clock
//  SC_LaneShiftBank_RESET_InHigh   in   1                     async reset, active high
//  SC_LaneShiftBank_clear_InLow    in   1                     sync clear of all lanes
//  SC_LaneShiftBank_load_InLow     in   1                     write data_InBUS into selected lane
//  SC_LaneShiftBank_cfg_InLow      in   1                     write dir/period into selected lane
//  SC_LaneShiftBank_enable_In      in   1                     global run (0 = pause all lanes)
//  SC_LaneShiftBank_lanesel_InBUS  in   LANESEL_WIDTH         target lane for load/cfg
//  SC_LaneShiftBank_data_InBUS     in   LANE_WIDTH            pattern to load
//  SC_LaneShiftBank_dir_In         in   2                     01 rotate left, 10 rotate right, 00/11 hold
//  SC_LaneShiftBank_period_InBUS   in   PERIOD_WIDTH          cycles per step; 0 = lane frozen
//  SC_LaneShiftBank_data_OutBUS    out  NUM_LANES*LANE_WIDTH  lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//  SC_LaneShiftBank_step_OutBUS    out  NUM_LANES             per-lane step pulse (LANESHIFT_STEP_OUT_EN only)
// BEHAVIOUR
//  - Reset (async, active high): all lane data 0, counters 0, dir 00, period 0; step_OutBUS 0.
//  - Outputs are registered; a write or rotation is visible on data_OutBUS the cycle after the edge.
//  - Left rotate: {r[W-2:0], r[W-1]}. Right rotate: {r[0], r[W-1:1]}.
//  - Per-lane counter cnt: lane active when enable_In=1, period!=0, dir in {01,10}.
//    Active: cnt==period-1 -> rotate, cnt<=0; else cnt<=cnt+1. Inactive: cnt and data hold.
//    period=1 -> rotate every cycle; period=P -> one step per P cycles.
//  - Priority per lane, per cycle: clear > load > cfg > rotate.
//    clear_InLow=0: every lane data<=DATA_FIXED_INIT, cnt<=0; dir/period retained.
//    load_InLow=0 (selected lane): data<=data_InBUS, cnt<=0, no rotation that cycle.
//    cfg_InLow=0 (selected lane): dir/period<=inputs, cnt<=0, no rotation that cycle.
//    load and cfg both low: both take effect on the selected lane.
//  - Unselected lanes keep rotating during load/cfg of another lane.
//  - lanesel_InBUS >= NUM_LANES: load/cfg ignored, no state change.
//  - Reducing period below current cnt+1: cnt restarts at 0 (cfg always clears cnt).
//  - Reset mid-operation: immediate return to reset state regardless of clock.
// CONFIGURATION
//  - Macro LANESHIFT_STEP_OUT_EN defined: step_OutBUS[i] pulses high for exactly one cycle,
//    aligned with the cycle lane i's new (rotated) data first appears; 0 on load/cfg/clear cycles.
//    Used to carry a rider (frog on log) along with the lane.
//  - Not defined: step_OutBUS port absent; no step registers synthesised.
// STRUCTURE
//  - Package sc_laneshift_pkg: dir encoding constants (DIR_HOLD=2'b00, DIR_LEFT=2'b01,
//    DIR_RIGHT=2'b10), default width constants.
//  - Sub-module sc_lane_shift_cell: one lane (data reg, dir/period regs, counter, step flag);
//    top generates NUM_LANES cells, decodes lanesel into per-lane load/cfg strobes, packs output bus.
// TESTING
//  - Reset: assert RESET mid-run -> data_OutBUS all 0, step 0 asynchronously.
//  - Load lane 2 = 16'h8001, cfg dir=01 period=1, enable=1 -> lane 2 shows 16'h0003 next cycle, then 16'h0006.
//  - Lane 5 = 16'h0001, dir=10 period=4 -> wraps to 16'h8000 after 4 cycles; step pulse every 4th cycle.
//  - clear_InLow=0 together with load lane 0 = 16'hFFFF -> all lanes DATA_FIXED_INIT, cfg retained.
//  - enable_In=0 for 10 cycles -> all lanes frozen, counters hold; resume continues phase.
//  - lanesel=7 with NUM_LANES=6, load/cfg -> no lane changes; period=0 lane never rotates.

Source files
------------

// File: rtl/sc_laneshift_pkg.sv
// Shared constants for the lane-shift bank: direction encoding and default geometry.
package sc_laneshift_pkg;

    localparam logic [1:0] DIR_HOLD  = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;

    localparam int DEF_NUM_LANES     = 8;
    localparam int DEF_LANE_WIDTH    = 16;
    localparam int DEF_PERIOD_WIDTH  = 8;
    localparam int DEF_LANESEL_WIDTH = 3;

endpackage

// File: rtl/sc_lane_shift_cell.sv
// One background lane: pattern register, direction/period config, step counter.
// Step flag register exists only when LANESHIFT_STEP_OUT_EN is defined.
module sc_lane_shift_cell
    import sc_laneshift_pkg::*;
#(
    parameter int                  LANE_WIDTH      = DEF_LANE_WIDTH,
    parameter int                  PERIOD_WIDTH    = DEF_PERIOD_WIDTH,
    parameter logic [LANE_WIDTH-1:0] DATA_FIXED_INIT = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    cfg,
    input  logic                    enable,
    input  logic [LANE_WIDTH-1:0]   data_in,
    input  logic [1:0]              dir_in,
    input  logic [PERIOD_WIDTH-1:0] period_in,
`ifdef LANESHIFT_STEP_OUT_EN
    output logic                    step,
`endif
    output logic [LANE_WIDTH-1:0]   data
);

    logic [1:0]              dir_reg;
    logic [PERIOD_WIDTH-1:0] period_reg;
    logic [PERIOD_WIDTH-1:0] cnt_reg;
    logic                    active;
    logic                    wrap;
    logic [LANE_WIDTH-1:0]   rotated;

    assign active  = enable && (period_reg != '0) &&
                     ((dir_reg == DIR_LEFT) || (dir_reg == DIR_RIGHT));
    assign wrap    = (cnt_reg == period_reg - PERIOD_WIDTH'(1));
    assign rotated = (dir_reg == DIR_LEFT) ? {data[LANE_WIDTH-2:0], data[LANE_WIDTH-1]}
                                           : {data[0], data[LANE_WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            dir_reg    <= DIR_HOLD;
            period_reg <= '0;
            cnt_reg    <= '0;
        end else if (clear) begin
            data    <= DATA_FIXED_INIT;
            cnt_reg <= '0;
        end else begin
            if (load) begin
                data    <= data_in;
                cnt_reg <= '0;
            end
            if (cfg) begin
                dir_reg    <= dir_in;
                period_reg <= period_in;
                cnt_reg    <= '0;
            end
            // A write to this lane suppresses its rotation for that cycle.
            if (!load && !cfg && active) begin
                if (wrap) begin
                    data    <= rotated;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + PERIOD_WIDTH'(1);
                end
            end
        end
    end

`ifdef LANESHIFT_STEP_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= 1'b0;
        end else begin
            step <= !clear && !load && !cfg && active && wrap;
        end
    end
`endif

endmodule

// File: rtl/sc_lane_shift_bank.sv
// Bank of independent rotating playfield lanes with per-lane load/config by index.
// Optional per-lane step pulse output enabled by LANESHIFT_STEP_OUT_EN.
module sc_lane_shift_bank
    import sc_laneshift_pkg::*;
#(
    parameter int                    NUM_LANES       = DEF_NUM_LANES,
    parameter int                    LANE_WIDTH      = DEF_LANE_WIDTH,
    parameter int                    PERIOD_WIDTH    = DEF_PERIOD_WIDTH,
    parameter int                    LANESEL_WIDTH   = DEF_LANESEL_WIDTH,
    parameter logic [LANE_WIDTH-1:0] DATA_FIXED_INIT = 16'h0000
) (
    input  logic                            SC_LaneShiftBank_CLOCK_50,
    input  logic                            SC_LaneShiftBank_RESET_InHigh,
    input  logic                            SC_LaneShiftBank_clear_InLow,
    input  logic                            SC_LaneShiftBank_load_InLow,
    input  logic                            SC_LaneShiftBank_cfg_InLow,
    input  logic                            SC_LaneShiftBank_enable_In,
    input  logic [LANESEL_WIDTH-1:0]        SC_LaneShiftBank_lanesel_InBUS,
    input  logic [LANE_WIDTH-1:0]           SC_LaneShiftBank_data_InBUS,
    input  logic [1:0]                      SC_LaneShiftBank_dir_In,
    input  logic [PERIOD_WIDTH-1:0]         SC_LaneShiftBank_period_InBUS,
`ifdef LANESHIFT_STEP_OUT_EN
    output logic [NUM_LANES-1:0]            SC_LaneShiftBank_step_OutBUS,
`endif
    output logic [NUM_LANES*LANE_WIDTH-1:0] SC_LaneShiftBank_data_OutBUS
);

    logic [NUM_LANES-1:0] load_lane;
    logic [NUM_LANES-1:0] cfg_lane;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            // Out-of-range lane indices match no cell, so the write is dropped.
            assign load_lane[gi] = !SC_LaneShiftBank_load_InLow &&
                                   (SC_LaneShiftBank_lanesel_InBUS == LANESEL_WIDTH'(gi));
            assign cfg_lane[gi]  = !SC_LaneShiftBank_cfg_InLow &&
                                   (SC_LaneShiftBank_lanesel_InBUS == LANESEL_WIDTH'(gi));

            sc_lane_shift_cell #(
                .LANE_WIDTH      (LANE_WIDTH),
                .PERIOD_WIDTH    (PERIOD_WIDTH),
                .DATA_FIXED_INIT (DATA_FIXED_INIT)
            ) u_cell (
                .clk       (SC_LaneShiftBank_CLOCK_50),
                .rst       (SC_LaneShiftBank_RESET_InHigh),
                .clear     (!SC_LaneShiftBank_clear_InLow),
                .load      (load_lane[gi]),
                .cfg       (cfg_lane[gi]),
                .enable    (SC_LaneShiftBank_enable_In),
                .data_in   (SC_LaneShiftBank_data_InBUS),
                .dir_in    (SC_LaneShiftBank_dir_In),
                .period_in (SC_LaneShiftBank_period_InBUS),
`ifdef LANESHIFT_STEP_OUT_EN
                .step      (SC_LaneShiftBank_step_OutBUS[gi]),
`endif
                .data      (SC_LaneShiftBank_data_OutBUS[gi*LANE_WIDTH +: LANE_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sc_lane_shift_bank.sv
// Randomized bench for sc_lane_shift_bank against an age-based lane model.
// Step output is checked when LANESHIFT_STEP_OUT_EN is defined.
module tb_sc_lane_shift_bank;

    localparam int NL = 6;
    localparam int W  = 16;
    localparam int PW = 8;
    localparam int SW = 3;
    localparam logic [W-1:0] INIT = 16'h1234;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_n = 1'b1;
    logic          load_n = 1'b1;
    logic          cfg_n = 1'b1;
    logic          en = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [W-1:0]  din = '0;
    logic [1:0]    dir = 2'b00;
    logic [PW-1:0] per = '0;
    logic [NL*W-1:0] dout;
`ifdef LANESHIFT_STEP_OUT_EN
    logic [NL-1:0] step;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: lane pattern, config, and active cycles elapsed since last restart.
    logic [W-1:0] m_data [NL];
    logic [1:0]   m_dir  [NL];
    int           m_per  [NL];
    int           m_age  [NL];
    logic         m_step [NL];

    always #5 clk = ~clk;

    sc_lane_shift_bank #(
        .NUM_LANES(NL), .LANE_WIDTH(W), .PERIOD_WIDTH(PW),
        .LANESEL_WIDTH(SW), .DATA_FIXED_INIT(INIT)
    ) dut (
        .SC_LaneShiftBank_CLOCK_50      (clk),
        .SC_LaneShiftBank_RESET_InHigh  (rst),
        .SC_LaneShiftBank_clear_InLow   (clear_n),
        .SC_LaneShiftBank_load_InLow    (load_n),
        .SC_LaneShiftBank_cfg_InLow     (cfg_n),
        .SC_LaneShiftBank_enable_In     (en),
        .SC_LaneShiftBank_lanesel_InBUS (sel),
        .SC_LaneShiftBank_data_InBUS    (din),
        .SC_LaneShiftBank_dir_In        (dir),
        .SC_LaneShiftBank_period_InBUS  (per),
`ifdef LANESHIFT_STEP_OUT_EN
        .SC_LaneShiftBank_step_OutBUS   (step),
`endif
        .SC_LaneShiftBank_data_OutBUS   (dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lane(input int i);
        return dout[i*W +: W];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_data[i] = '0; m_dir[i] = 2'b00; m_per[i] = 0; m_age[i] = 0; m_step[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < NL; i++) begin
            bit ld, cf;
            ld = !load_n && (int'(sel) == i);
            cf = !cfg_n && (int'(sel) == i);
            m_step[i] = 1'b0;
            if (!clear_n) begin
                m_data[i] = INIT;
                m_age[i]  = 0;
            end else begin
                if (ld) begin m_data[i] = din; m_age[i] = 0; end
                if (cf) begin m_dir[i] = dir; m_per[i] = int'(per); m_age[i] = 0; end
                if (!ld && !cf && en && m_per[i] != 0 && (m_dir[i] == 2'b01 || m_dir[i] == 2'b10)) begin
                    m_age[i]++;
                    if (m_age[i] % m_per[i] == 0) begin
                        if (m_dir[i] == 2'b01)
                            m_data[i] = (m_data[i] << 1) | (m_data[i] >> (W-1));
                        else
                            m_data[i] = (m_data[i] >> 1) | (m_data[i] << (W-1));
                        m_step[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NL; i++) begin
            check($sformatf("lane%0d", i), 32'(lane(i)), 32'(m_data[i]));
`ifdef LANESHIFT_STEP_OUT_EN
            check($sformatf("step%0d", i), 32'(step[i]), 32'(m_step[i]));
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        $display("cyc %0d clr=%b ld=%b cf=%b en=%b sel=%0d din=%h dir=%b per=%0d l0=%h l2=%h l5=%h",
                 cyc, clear_n, load_n, cfg_n, en, sel, din, dir, per, lane(0), lane(2), lane(5));
        check_all();
    endtask

    task automatic idle();
        clear_n = 1'b1; load_n = 1'b1; cfg_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check("reset_bus", 32'(dout[31:0]), 32'h0);
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Lane 2: 8001, rotate left every cycle.
        en = 1'b1; sel = 3'd2; din = 16'h8001; dir = 2'b01; per = 8'd1;
        load_n = 1'b0; cfg_n = 1'b0;
        cycle();
        check("l2_load", 32'(lane(2)), 32'h8001);
        idle();
        cycle();
        check("l2_rot1", 32'(lane(2)), 32'h0003);
        cycle();
        check("l2_rot2", 32'(lane(2)), 32'h0006);

        // Lane 5: 0001, rotate right every 4 cycles.
        sel = 3'd5; din = 16'h0001; dir = 2'b10; per = 8'd4;
        load_n = 1'b0; cfg_n = 1'b0;
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("l5_hold", 32'(lane(5)), 32'h0001);
        end
        cycle();
        check("l5_wrap", 32'(lane(5)), 32'h8000);

        // Clear wins over a simultaneous load; config survives.
        clear_n = 1'b0; load_n = 1'b0; sel = 3'd0; din = 16'hFFFF;
        cycle();
        check("clr_l0", 32'(lane(0)), 32'(INIT));
        idle();
        cycle();
        check("clr_l2_rot", 32'(lane(2)), 32'h2468);

        // Pause for 10 cycles, then resume.
        en = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        en = 1'b1;
        for (int k = 0; k < 6; k++) cycle();

        // Out-of-range lane index is ignored.
        sel = 3'd7; din = 16'hBEEF; dir = 2'b01; per = 8'd2;
        load_n = 1'b0; cfg_n = 1'b0;
        cycle();
        sel = 3'd6;
        cycle();
        idle();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            clear_n = ($urandom_range(0, 49) != 0);
            load_n  = ($urandom_range(0, 9) != 0);
            cfg_n   = ($urandom_range(0, 9) != 0);
            en      = ($urandom_range(0, 9) != 0);
            sel     = SW'($urandom_range(0, 7));
            din     = W'($urandom);
            dir     = 2'($urandom);
            per     = ($urandom_range(0, 7) == 0) ? PW'($urandom) : PW'($urandom_range(0, 5));
            cycle();
        end
        idle();

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst", 32'(dout[31:0]) | 32'(dout[NL*W-1:32] != '0), 32'h0);
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        for (int k = 0; k < 40; k++) begin
            load_n = ($urandom_range(0, 3) != 0);
            cfg_n  = ($urandom_range(0, 3) != 0);
            en     = 1'b1;
            sel    = SW'($urandom_range(0, 7));
            din    = W'($urandom);
            dir    = 2'($urandom);
            per    = PW'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
